cpu_host_seq: RTL and testbench
===============================

Name: cpu_host_seq

Overview:
- Host-side initiator for the processor's req/done run handshake.
- Per run: preloads data memory from an input byte stream, pulses req, waits for done with a timeout, then streams a result window of data memory back out.
- Sits in the harness/SoC top beside the processor. It owns the data-memory port while loading and draining; the top-level mux gives that port to the core otherwise.

Parameters:
- AW, 8, data-memory address width.
- LOAD_BASE, 0, first address written during load.
- LOAD_LEN, 64, bytes loaded per run (0 = skip load).
- RES_BASE, 64, first address read during drain.
- RES_LEN, 32, bytes drained per run (0 = skip drain).
- TIMEOUT, 4096, max cycles waited for done after req.
- CW, 16, cycle-counter width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  begin a run; sampled only in IDLE.
- in_valid  in  1  load byte available.
- in_data  in  8  load byte.
- in_ready  out  1  host accepts in_data this cycle.
- req  out  1  run request to processor, one-cycle pulse.
- done  in  1  processor completion flag, level.
- mem_wr_en  out  1  data-memory write enable.
- mem_addr  out  AW  data-memory address.
- mem_wr_data  out  8  data-memory write data.
- mem_rd_data  in  8  data-memory read data, combinational on mem_addr.
- mem_own  out  1  host owns memory port (top-level mux select).
- out_valid  out  1  drained byte valid.
- out_data  out  8  drained byte.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  not IDLE.
- run_ok  out  1  last run completed by done; sticky until next start.
- timeout_err  out  1  last run timed out; sticky until next start.
- cycles  out  CW  cycles from req to done of last run, saturating.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE, LOAD, REQ, WAIT, DRAIN.
- IDLE:
  - start=1 clears run_ok, timeout_err and cycles.
  - Next state is LOAD if LOAD_LEN>0, else REQ.
  - start while busy is ignored.
- LOAD:
  - mem_own=1, in_ready=1, mem_addr=LOAD_BASE+idx.
  - Write byte: mem_wr_en=in_valid, mem_wr_data=in_data.
  - idx advances only on in_valid; in_valid low stalls with no write.
  - After write LOAD_LEN-1 → REQ.
- REQ:
  - req=1 for exactly one cycle; mem_own=0; wait counter cleared.
  - Next state is WAIT.
- WAIT:
  - mem_own=0; done is first sampled the cycle after REQ, so a stale done from the prior run is never taken.
  - Wait counter increments each cycle; cycles saturates at 2^CW-1.
  - done=1: run_ok=1, latch cycles, go to DRAIN (or IDLE if RES_LEN=0).
  - Counter reaching TIMEOUT with done=0: timeout_err=1, go to IDLE, skip drain.
  - done and timeout in the same cycle: done wins.
- DRAIN:
  - mem_own=1, mem_wr_en=0, mem_addr=RES_BASE+idx.
  - out_data=mem_rd_data, out_valid=1.
  - Advance on out_valid&out_ready; out_data holds stable while stalled.
  - After transfer RES_LEN-1 → IDLE.
- Address arithmetic: AW bits, wraps modulo 2^AW.
- Rules:
  - mem_wr_en is never high outside LOAD.
  - in_ready and out_valid are 0 outside LOAD and DRAIN respectively.
- Reset mid-run: immediate return to IDLE with all outputs 0; a pending req pulse is cancelled.

Optional Feature:
- Macro: CPU_HOST_CHECKSUM_EN.
- Defined:
  - Adds output port checksum[7:0], an 8-bit modular sum of all bytes accepted in LOAD plus all bytes transferred in DRAIN.
  - Cleared on start; valid when returning to IDLE.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Package cpu_host_pkg:
  - state enum host_state_t {IDLE, LOAD, REQ, WAIT, DRAIN}.
  - Default constants for LOAD_BASE, RES_BASE, TIMEOUT.
- Sub-module sat_counter (width param, clear, enable, saturating count, terminal flag), instantiated twice: wait/cycles counter and byte index.

Test Plan:
- LOAD_LEN=4, bytes 11,22,33,44 with in_valid gaps → writes at addr 0..3 only on valid cycles; one req pulse after the 4th write.
- done asserted 10 cycles after req → cycles=10, run_ok=1, drain begins next cycle at addr 64.
- Drain RES_LEN=4, out_ready toggling every cycle → 4 transfers with data 0xA0..0xA3, out_data stable while stalled; return to IDLE, busy=0.
- done held low, TIMEOUT=16 → timeout_err=1 at count 16, no drain, mem_own=0.
- done stuck high from prior run when req pulses → not taken in REQ cycle; taken first WAIT cycle, cycles=1.
- reset asserted mid-LOAD at idx 2 → all outputs 0 same cycle; a new start reloads from LOAD_BASE; with macro defined, checksum of 01,02,03,04 drained back = 0x14.

Source files
------------

// File: rtl/cpu_host_seq_pkg.sv
// Shared types and defaults for the host run sequencer.
// Holds the FSM state encoding plus helpers that size the internal counters.
package cpu_host_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    REQ   = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } host_state_t;

  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_RES_BASE  = 64;
  localparam int DEF_TIMEOUT   = 4096;

  // Byte index only has to reach the longer of the two windows minus one.
  function automatic int idx_width(input int load_len, input int res_len);
    int m;
    m = (load_len > res_len) ? load_len : res_len;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  // Wait counter must hold TIMEOUT even if the reported cycle count is narrower.
  function automatic int wait_width(input int cw, input int timeout);
    int need;
    need = $clog2(timeout + 1);
    return (need > cw) ? need : cw;
  endfunction

endpackage

// File: rtl/cpu_host_seq_sat_counter.sv
// Up-counter that holds at all-ones; clear has priority over enable.
// at_term flags the current count equal to term, one cycle before the step that would pass it.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign at_term = (count_q == term);

endmodule

// File: rtl/cpu_host_seq.sv
// Host initiator: preload data memory, pulse req, wait for done (with timeout), drain a result window.
// Load/drain stall on in_valid / out_ready; CPU_HOST_CHECKSUM_EN adds an 8-bit checksum output.
module cpu_host_seq
  import cpu_host_pkg::*;
#(
  parameter int AW        = 8,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = 64,
  parameter int RES_BASE  = DEF_RES_BASE,
  parameter int RES_LEN   = 32,
  parameter int TIMEOUT   = DEF_TIMEOUT,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          req,
  input  logic          done,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          mem_own,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          run_ok,
  output logic          timeout_err,
  output logic [CW-1:0] cycles
`ifdef CPU_HOST_CHECKSUM_EN
  ,
  output logic [7:0]    checksum
`endif
);

  localparam int IW = idx_width(LOAD_LEN, RES_LEN);
  localparam int WW = wait_width(CW, TIMEOUT);
  localparam logic [IW-1:0] LOAD_LAST = IW'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
  localparam logic [IW-1:0] RES_LAST  = IW'((RES_LEN > 0) ? RES_LEN - 1 : 0);
  localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  host_state_t   state_q, state_d;
  logic          run_ok_q, run_ok_d;
  logic          timeout_err_q, timeout_err_d;
  logic [CW-1:0] cycles_q, cycles_d;

  logic          idx_clr, idx_en, idx_last;
  logic [IW-1:0] idx, idx_term;
  logic          wcnt_clr, wcnt_en, wcnt_last;
  logic [WW-1:0] wcnt, wcnt_inc;
  logic [CW-1:0] cycles_sat;
  logic [AW-1:0] load_addr, res_addr;

`ifdef CPU_HOST_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
`endif

  sat_counter #(.W(IW)) u_idx_cnt (
    .clk     (clk),
    .rst     (reset),
    .clr     (idx_clr),
    .en      (idx_en),
    .term    (idx_term),
    .count   (idx),
    .at_term (idx_last)
  );

  sat_counter #(.W(WW)) u_wait_cnt (
    .clk     (clk),
    .rst     (reset),
    .clr     (wcnt_clr),
    .en      (wcnt_en),
    .term    (WAIT_LAST),
    .count   (wcnt),
    .at_term (wcnt_last)
  );

  assign idx_term  = (state_q == DRAIN) ? RES_LAST : LOAD_LAST;
  assign load_addr = AW'(LOAD_BASE) + AW'(idx);
  assign res_addr  = AW'(RES_BASE) + AW'(idx);

  // Count including the current WAIT cycle; wcnt never exceeds TIMEOUT-1 here so no wrap.
  assign wcnt_inc = wcnt + WW'(1);
  always_comb begin
    cycles_sat = wcnt_inc[CW-1:0];
    if ((wcnt_inc >> CW) != '0) begin
      cycles_sat = '1;
    end
  end

  always_comb begin
    state_d       = state_q;
    run_ok_d      = run_ok_q;
    timeout_err_d = timeout_err_q;
    cycles_d      = cycles_q;
    in_ready      = 1'b0;
    req           = 1'b0;
    mem_wr_en     = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = '0;
    mem_own       = 1'b0;
    out_valid     = 1'b0;
    out_data      = '0;
    idx_clr       = 1'b1;
    idx_en        = 1'b0;
    wcnt_clr      = 1'b0;
    wcnt_en       = 1'b0;
`ifdef CPU_HOST_CHECKSUM_EN
    sum_d         = sum_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          run_ok_d      = 1'b0;
          timeout_err_d = 1'b0;
          cycles_d      = '0;
`ifdef CPU_HOST_CHECKSUM_EN
          sum_d         = '0;
`endif
          state_d       = (LOAD_LEN > 0) ? LOAD : REQ;
        end
      end

      LOAD: begin
        mem_own     = 1'b1;
        in_ready    = 1'b1;
        idx_clr     = 1'b0;
        mem_addr    = load_addr;
        mem_wr_en   = in_valid;
        mem_wr_data = in_data;
        if (in_valid) begin
          idx_en = 1'b1;
`ifdef CPU_HOST_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (idx_last) begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        req      = 1'b1;
        wcnt_clr = 1'b1;
        state_d  = WAIT;
      end

      // done is not looked at in REQ, so a level left over from the last run cannot short-circuit this one.
      WAIT: begin
        wcnt_en = 1'b1;
        if (done) begin
          run_ok_d = 1'b1;
          cycles_d = cycles_sat;
          state_d  = (RES_LEN > 0) ? DRAIN : IDLE;
        end else if (wcnt_last) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end

      DRAIN: begin
        mem_own   = 1'b1;
        idx_clr   = 1'b0;
        mem_addr  = res_addr;
        out_valid = 1'b1;
        out_data  = mem_rd_data;
        if (out_ready) begin
          idx_en = 1'b1;
`ifdef CPU_HOST_CHECKSUM_EN
          sum_d  = sum_q + mem_rd_data;
`endif
          if (idx_last) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      run_ok_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      cycles_q      <= '0;
    end else begin
      state_q       <= state_d;
      run_ok_q      <= run_ok_d;
      timeout_err_q <= timeout_err_d;
      cycles_q      <= cycles_d;
    end
  end

`ifdef CPU_HOST_CHECKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

  assign busy        = (state_q != IDLE);
  assign run_ok      = run_ok_q;
  assign timeout_err = timeout_err_q;
  assign cycles      = cycles_q;

endmodule

// File: tb/tb_cpu_host_seq.sv
// Directed bench for cpu_host_seq with LOAD_LEN=4, RES_LEN=4, TIMEOUT=16.
module tb_cpu_host_seq;

  logic       clk;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       req;
  logic       done;
  logic       mem_wr_en;
  logic [7:0] mem_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data;
  logic       mem_own;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       busy;
  logic       run_ok;
  logic       timeout_err;
  logic [15:0] cycles;
`ifdef CPU_HOST_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int checks = 0;
  int failures = 0;

  // Result window content: byte at RES_BASE+n reads as pat_base+n.
  logic [7:0] pat_base;
  assign mem_rd_data = pat_base + (mem_addr - 8'd64);

  logic [7:0] flags;
  assign flags = {busy, req, mem_own, in_ready, out_valid, mem_wr_en, run_ok, timeout_err};

  logic [7:0] lbytes [4];

  cpu_host_seq #(
    .AW(8), .LOAD_BASE(0), .LOAD_LEN(4), .RES_BASE(64), .RES_LEN(4), .TIMEOUT(16), .CW(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .req(req), .done(done),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .mem_own(mem_own),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .run_ok(run_ok), .timeout_err(timeout_err), .cycles(cycles)
`ifdef CPU_HOST_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (flags !== 8'h00) begin failures++; $display("FAIL reset_flags got=%b exp=%b", flags, 8'h00); end
    checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL reset_cycles got=%0d exp=0", cycles); end
    checks++; if ({mem_addr, out_data, mem_wr_data} !== 24'h0) begin failures++; $display("FAIL reset_buses got=%h exp=0", {mem_addr, out_data, mem_wr_data}); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load();
    logic [6:0] vpat;
    int k;
    vpat = 7'b1100101;
    k = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_valid = vpat[i];
      in_data  = vpat[i] ? lbytes[k] : 8'hFF;
      #1;
      checks++; if (flags !== {4'b1011, 1'b0, vpat[i], 2'b00}) begin failures++; $display("FAIL load_flags cyc=%0d got=%b exp=%b", i, flags, {4'b1011, 1'b0, vpat[i], 2'b00}); end
      if (vpat[i]) begin
        checks++; if (mem_addr !== 8'(k)) begin failures++; $display("FAIL load_addr got=%0d exp=%0d", mem_addr, k); end
        checks++; if (mem_wr_data !== lbytes[k]) begin failures++; $display("FAIL load_data got=%h exp=%h", mem_wr_data, lbytes[k]); end
        k++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++; if (flags !== 8'b1100_0000) begin failures++; $display("FAIL req_pulse got=%b exp=%b", flags, 8'b1100_0000); end
  endtask

  task automatic test_done_wait();
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      done = (i == 10);
      #1;
      checks++; if (flags !== 8'b1000_0000) begin failures++; $display("FAIL wait_flags cyc=%0d got=%b exp=%b", i, flags, 8'b1000_0000); end
    end
    @(negedge clk);
    done = 1'b0;
    #1;
    checks++; if (flags !== 8'b1010_1010) begin failures++; $display("FAIL drain_entry_flags got=%b exp=%b", flags, 8'b1010_1010); end
    checks++; if (cycles !== 16'd10) begin failures++; $display("FAIL cycles_10 got=%0d exp=10", cycles); end
    checks++; if (mem_addr !== 8'd64) begin failures++; $display("FAIL drain_addr0 got=%0d exp=64", mem_addr); end
  endtask

  task automatic test_drain();
    int k;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      out_ready = (i % 2) == 1;
      #1;
      checks++; if (out_valid !== 1'b1 || mem_wr_en !== 1'b0) begin failures++; $display("FAIL drain_valid got=%b%b exp=10", out_valid, mem_wr_en); end
      checks++; if (mem_addr !== 8'(64 + k)) begin failures++; $display("FAIL drain_addr got=%0d exp=%0d", mem_addr, 64 + k); end
      checks++; if (out_data !== 8'(8'hA0 + k)) begin failures++; $display("FAIL drain_data got=%h exp=%h", out_data, 8'(8'hA0 + k)); end
      if (out_ready) k++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    checks++; if (flags !== 8'b0000_0010) begin failures++; $display("FAIL drain_exit_flags got=%b exp=%b", flags, 8'b0000_0010); end
    checks++; if (out_data !== 8'h00 || cycles !== 16'd10) begin failures++; $display("FAIL idle_hold got=%h/%0d exp=00/10", out_data, cycles); end
  endtask

  task automatic test_timeout();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i);
      #1;
      if (i == 0) begin
        checks++; if (flags !== 8'b1011_0100) begin failures++; $display("FAIL start_clears got=%b exp=%b", flags, 8'b1011_0100); end
        checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL start_clears_cycles got=%0d exp=0", cycles); end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    done = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      checks++; if (flags !== 8'b1000_0000) begin failures++; $display("FAIL to_wait cyc=%0d got=%b exp=%b", i, flags, 8'b1000_0000); end
    end
    @(negedge clk); #1;
    checks++; if (flags !== 8'b0000_0001) begin failures++; $display("FAIL timeout_flags got=%b exp=%b", flags, 8'b0000_0001); end
    checks++; if (cycles !== 16'd0) begin failures++; $display("FAIL timeout_cycles got=%0d exp=0", cycles); end
  endtask

  task automatic test_stale_done();
    done = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    checks++; if (flags !== 8'b1100_0000) begin failures++; $display("FAIL stale_req got=%b exp=%b", flags, 8'b1100_0000); end
    @(negedge clk); #1;
    checks++; if (flags !== 8'b1000_0000) begin failures++; $display("FAIL stale_wait got=%b exp=%b", flags, 8'b1000_0000); end
    @(negedge clk);
    done = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (flags !== 8'b1010_1010) begin failures++; $display("FAIL stale_drain got=%b exp=%b", flags, 8'b1010_1010); end
    checks++; if (cycles !== 16'd1) begin failures++; $display("FAIL stale_cycles got=%0d exp=1", cycles); end
    for (int i = 0; i < 4; i++) @(negedge clk);
    out_ready = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stale_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_load();
    pat_base = 8'h01;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55; @(negedge clk);
    in_data = 8'h66; @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (flags !== 8'h00) begin failures++; $display("FAIL midreset_flags got=%b exp=%b", flags, 8'h00); end
    checks++; if (mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin failures++; $display("FAIL midreset_bus got=%h/%h exp=00/00", mem_addr, mem_wr_data); end
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(i + 1);
      #1;
      checks++; if (mem_wr_en !== 1'b1 || mem_addr !== 8'(i)) begin failures++; $display("FAIL reload_addr got=%b/%0d exp=1/%0d", mem_wr_en, mem_addr, i); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_data !== 8'(i + 1)) begin failures++; $display("FAIL reload_drain got=%h exp=%h", out_data, 8'(i + 1)); end
      @(negedge clk);
    end
    out_ready = 1'b0;
    #1;
    checks++; if (flags !== 8'b0000_0010) begin failures++; $display("FAIL reload_idle got=%b exp=%b", flags, 8'b0000_0010); end
`ifdef CPU_HOST_CHECKSUM_EN
    checks++; if (checksum !== 8'h14) begin failures++; $display("FAIL checksum got=%h exp=14", checksum); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    done = 1'b0;
    out_ready = 1'b0;
    pat_base = 8'hA0;
    lbytes[0] = 8'h11; lbytes[1] = 8'h22; lbytes[2] = 8'h33; lbytes[3] = 8'h44;
    test_reset();
    test_load();
    test_done_wait();
    test_drain();
    test_timeout();
    test_stale_done();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
